// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: steps the 4-lane vector memory through an n-element
// operation in groups of four, holding addresses during execute and pulsing
// the memory write enable once per group. Tail groups get a partial lane mask.
module vec_mem_sequencer #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] base_j,
   input  logic [ADDR_W-1:0] n,
   input  logic              algorithm,
   input  logic              exec_done,
   output logic [ADDR_W-1:0] mem_i,
   output logic [ADDR_W-1:0] mem_j,
   output logic [ADDR_W-1:0] mem_n,
   output logic              mem_algorithm,
   output logic              wr_wom,
   output logic [3:0]        lane_mask,
   output logic              exec_start,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CMP_W = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [ADDR_W-1:0] bi_q, bi_d;
   logic [ADDR_W-1:0] bj_q, bj_d;
   logic [ADDR_W-1:0] n_d;
   logic              alg_d;
   logic [ADDR_W-1:0] rem;
   logic              last_grp;

   logic [ADDR_W-1:0] mem_i_d, mem_j_d;
   logic [3:0]        lane_mask_d;
   logic              wr_wom_d, exec_start_d, busy_d, done_d;

   // Extra bit keeps k+4 >= n correct when n is close to 2^ADDR_W.
   assign last_grp = ({1'b0, k_q} + CMP_W'(4)) >= {1'b0, mem_n};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = (n == '0) ? S_DONE : S_LOAD;
         S_LOAD:  state_d = S_EXEC;
         S_EXEC:  if (exec_done) state_d = S_WRITE;
         S_WRITE: state_d = S_NEXT;
         S_NEXT:  state_d = last_grp ? S_DONE : S_LOAD;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values for operand latches, group offset and registered outputs.
   always_comb begin
      k_d          = k_q;
      bi_d         = bi_q;
      bj_d         = bj_q;
      n_d          = mem_n;
      alg_d        = mem_algorithm;
      mem_i_d      = mem_i;
      mem_j_d      = mem_j;
      lane_mask_d  = lane_mask;
      rem          = '0;

      if (state_q == S_IDLE && start) begin
         k_d = '0;
         if (n != '0) begin
            bi_d  = base_i;
            bj_d  = base_j;
            n_d   = n;
            alg_d = algorithm;
         end
      end
      if (state_q == S_NEXT) k_d = k_q + ADDR_W'(4);

      // Addresses and mask are captured on entry to LOAD and held to NEXT.
      if (state_d == S_LOAD) begin
         mem_i_d     = bi_d + k_d;
         mem_j_d     = bj_d + k_d;
         rem         = n_d - k_d;
         lane_mask_d = (rem >= ADDR_W'(4)) ? 4'hF
                                           : 4'((5'd1 << rem[1:0]) - 5'd1);
      end

      wr_wom_d     = (state_d == S_WRITE);
      exec_start_d = (state_q == S_LOAD) && (state_d == S_EXEC);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q           <= '0;
         bi_q          <= '0;
         bj_q          <= '0;
         mem_n         <= '0;
         mem_algorithm <= 1'b0;
         mem_i         <= '0;
         mem_j         <= '0;
         lane_mask     <= 4'h0;
         wr_wom        <= 1'b0;
         exec_start    <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         k_q           <= k_d;
         bi_q          <= bi_d;
         bj_q          <= bj_d;
         mem_n         <= n_d;
         mem_algorithm <= alg_d;
         mem_i         <= mem_i_d;
         mem_j         <= mem_j_d;
         lane_mask     <= lane_mask_d;
         wr_wom        <= wr_wom_d;
         exec_start    <= exec_start_d;
         busy          <= busy_d;
         done          <= done_d;
      end
   end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Testbench for vec_mem_sequencer: directed scenarios plus randomized
// operations, checked cycle by cycle against a group-level reference model.
module tb_vec_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] base_i, base_j, n;
   logic        algorithm;
   logic        exec_done;
   logic [31:0] mem_i, mem_j, mem_n;
   logic        mem_algorithm;
   logic        wr_wom;
   logic [3:0]  lane_mask;
   logic        exec_start;
   logic        busy;
   logic        done;

   int n_chk  = 0;
   int n_fail = 0;

   vec_mem_sequencer #(.ADDR_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .base_i        (base_i),
      .base_j        (base_j),
      .n             (n),
      .algorithm     (algorithm),
      .exec_done     (exec_done),
      .mem_i         (mem_i),
      .mem_j         (mem_j),
      .mem_n         (mem_n),
      .mem_algorithm (mem_algorithm),
      .wr_wom        (wr_wom),
      .lane_mask     (lane_mask),
      .exec_start    (exec_start),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scramble inputs the DUT must ignore in the current state.
   task automatic noise(input bit allow_start);
      base_i    = $urandom;
      base_j    = $urandom;
      n         = $urandom;
      algorithm = 1'($urandom_range(0, 1));
      start     = allow_start ? 1'($urandom_range(0, 1)) : 1'b0;
      exec_done = 1'($urandom_range(0, 1));
   endtask

   // Idle cycles with stray exec_done: nothing may happen.
   task automatic idle_cycles(input int cnt);
      for (int c = 0; c < cnt; c++) begin
         noise(1'b0);
         step();
         chk("idle_busy", 64'(busy), 64'd0);
         chk("idle_wr",   64'(wr_wom), 64'd0);
         chk("idle_done", 64'(done), 64'd0);
      end
   endtask

   // One operation: the model lists the groups (addresses, mask) and the
   // bench walks LOAD / EXEC(lat) / WRITE / NEXT per group, then DONE.
   task automatic run_op(input logic [31:0] bi, input logic [31:0] bj,
                         input logic [31:0] nn, input logic alg,
                         input int lat_lo, input int lat_hi);
      int          groups;
      int          lat;
      int          rem;
      logic [31:0] ei, ej;
      logic [3:0]  em;
      start = 1'b1; base_i = bi; base_j = bj; n = nn; algorithm = alg;
      exec_done = 1'($urandom_range(0, 1));
      step();
      if (nn == 32'd0) begin
         chk("n0_done", 64'(done), 64'd1);
         chk("n0_busy", 64'(busy), 64'd1);
         chk("n0_wr",   64'(wr_wom), 64'd0);
         chk("n0_xs",   64'(exec_start), 64'd0);
         noise(1'b1);
         step();
         chk("n0_done_end", 64'(done), 64'd0);
         chk("n0_busy_end", 64'(busy), 64'd0);
         start = 1'b0;
         return;
      end
      groups = (int'(nn) + 3) / 4;
      for (int g = 0; g < groups; g++) begin
         ei  = bi + 32'(4 * g);
         ej  = bj + 32'(4 * g);
         rem = int'(nn) - 4 * g;
         em  = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
         // LOAD
         chk("ld_busy", 64'(busy), 64'd1);
         chk("ld_mem_i", 64'(mem_i), 64'(ei));
         chk("ld_mem_j", 64'(mem_j), 64'(ej));
         chk("ld_mask", 64'(lane_mask), 64'(em));
         chk("ld_wr", 64'(wr_wom), 64'd0);
         chk("ld_xs", 64'(exec_start), 64'd0);
         chk("ld_mem_n", 64'(mem_n), 64'(nn));
         chk("ld_alg", 64'(mem_algorithm), 64'(alg));
         noise(1'b1);
         step();
         // EXEC, completing after lat stall cycles
         lat = $urandom_range(lat_lo, lat_hi);
         for (int c = 0; c <= lat; c++) begin
            chk("ex_xs", 64'(exec_start), (c == 0) ? 64'd1 : 64'd0);
            chk("ex_wr", 64'(wr_wom), 64'd0);
            chk("ex_mem_i", 64'(mem_i), 64'(ei));
            chk("ex_mem_j", 64'(mem_j), 64'(ej));
            chk("ex_mask", 64'(lane_mask), 64'(em));
            chk("ex_done", 64'(done), 64'd0);
            noise(1'b1);
            exec_done = (c == lat);
            step();
         end
         // WRITE
         chk("wr_wr", 64'(wr_wom), 64'd1);
         chk("wr_mem_i", 64'(mem_i), 64'(ei));
         chk("wr_mem_j", 64'(mem_j), 64'(ej));
         chk("wr_mask", 64'(lane_mask), 64'(em));
         chk("wr_xs", 64'(exec_start), 64'd0);
         noise(1'b1);
         step();
         // NEXT
         chk("nx_wr", 64'(wr_wom), 64'd0);
         chk("nx_mem_i", 64'(mem_i), 64'(ei));
         chk("nx_busy", 64'(busy), 64'd1);
         chk("nx_done", 64'(done), 64'd0);
         noise(1'b1);
         step();
      end
      // DONE
      chk("dn_done", 64'(done), 64'd1);
      chk("dn_busy", 64'(busy), 64'd1);
      chk("dn_wr", 64'(wr_wom), 64'd0);
      chk("dn_mem_n", 64'(mem_n), 64'(nn));
      noise(1'b1);
      step();
      chk("end_done", 64'(done), 64'd0);
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_mem_n", 64'(mem_n), 64'(nn));
      chk("end_alg", 64'(mem_algorithm), 64'(alg));
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; exec_done = 1'b0;
      base_i = '0; base_j = '0; n = '0; algorithm = 1'b0;
      step();
      step();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_i", 64'(mem_i), 64'd0);
      chk("rst_mask", 64'(lane_mask), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      idle_cycles(2);

      // Full groups, tail group, empty operation, long stall.
      run_op(32'd0, 32'd0, 32'd8, 1'b0, 0, 0);
      idle_cycles(2);
      run_op(32'd16, 32'd32, 32'd6, 1'b1, 0, 2);
      idle_cycles(2);
      run_op(32'd100, 32'd200, 32'd0, 1'b1, 0, 0);
      idle_cycles(2);
      run_op(32'd40, 32'd80, 32'd5, 1'b0, 5, 5);
      idle_cycles(3);

      // Reset while in EXEC: outputs clear at once, no done pulse.
      start = 1'b1; base_i = 32'd8; base_j = 32'd12; n = 32'd12; algorithm = 1'b1;
      exec_done = 1'b0;
      step();
      start = 1'b0;
      step();
      chk("pre_rst_xs", 64'(exec_start), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_mem_i", 64'(mem_i), 64'd0);
      chk("arst_mem_j", 64'(mem_j), 64'd0);
      chk("arst_mem_n", 64'(mem_n), 64'd0);
      chk("arst_alg", 64'(mem_algorithm), 64'd0);
      chk("arst_mask", 64'(lane_mask), 64'd0);
      chk("arst_xs", 64'(exec_start), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_wr", 64'(wr_wom), 64'd0);
      step();
      chk("arst_hold_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      idle_cycles(2);
      run_op(32'd4, 32'd4, 32'd4, 1'b0, 0, 0);
      idle_cycles(1);

      // Address wrap: second group lands on 0x00000002.
      run_op(32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'd8, 1'b1, 0, 1);
      idle_cycles(1);

      // Randomized operations.
      for (int t = 0; t < 25; t++) begin
         run_op($urandom, $urandom, 32'($urandom_range(0, 13)),
                1'($urandom_range(0, 1)), 0, 3);
         idle_cycles($urandom_range(1, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
